// File: rtl/carry_sum_stage.sv
// carry_sum_stage: Kogge-Stone carry resolution and registered sum behind a valid/ready handshake.
// Define CARRY_SUM_MID_REG_EN to insert a register slice between the prefix tree and the sum XOR.
module carry_sum_stage #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] h,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] grp_g, grp_p;
    logic [WIDTH-1:0] s_h, s_g, s_p;
    logic             s_valid, s_cin, s_ready;
    logic [WIDTH:0]   c;
    logic             out_load;
    logic             out_valid_q, out_valid_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    // Descending i keeps reads of i-d on the previous prefix level.
    always_comb begin
        grp_g = g;
        grp_p = p;
        for (int d = 1; d < WIDTH; d = d * 2) begin
            for (int i = WIDTH - 1; i >= d; i--) begin
                grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - d]);
                grp_p[i] = grp_p[i] & grp_p[i - d];
            end
        end
    end

    assign s_ready = !out_valid_q || out_ready;

`ifdef CARRY_SUM_MID_REG_EN
    logic             mid_valid_q, mid_valid_d, mid_cin_q, mid_cin_d, mid_load;
    logic [WIDTH-1:0] mid_h_q, mid_h_d, mid_g_q, mid_g_d, mid_p_q, mid_p_d;

    assign in_ready = !mid_valid_q || s_ready;

    always_comb begin
        mid_load    = in_valid && in_ready;
        mid_valid_d = in_ready ? in_valid : mid_valid_q;
        mid_h_d     = mid_load ? h : mid_h_q;
        mid_g_d     = mid_load ? grp_g : mid_g_q;
        mid_p_d     = mid_load ? grp_p : mid_p_q;
        mid_cin_d   = mid_load ? cin : mid_cin_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mid_valid_q <= 1'b0;
            mid_h_q     <= '0;
            mid_g_q     <= '0;
            mid_p_q     <= '0;
            mid_cin_q   <= 1'b0;
        end else begin
            mid_valid_q <= mid_valid_d;
            mid_h_q     <= mid_h_d;
            mid_g_q     <= mid_g_d;
            mid_p_q     <= mid_p_d;
            mid_cin_q   <= mid_cin_d;
        end
    end

    assign s_valid = mid_valid_q;
    assign s_h     = mid_h_q;
    assign s_g     = mid_g_q;
    assign s_p     = mid_p_q;
    assign s_cin   = mid_cin_q;
`else
    assign in_ready = s_ready;
    assign s_valid  = in_valid;
    assign s_h      = h;
    assign s_g      = grp_g;
    assign s_p      = grp_p;
    assign s_cin    = cin;
`endif

    // Carry-in folds in as a generate below bit 0.
    assign c = {s_g | (s_p & {WIDTH{s_cin}}), s_cin};

    always_comb begin
        out_load    = s_valid && s_ready;
        out_valid_d = s_ready ? s_valid : out_valid_q;
        sum_d       = out_load ? (s_h ^ c[WIDTH-1:0]) : sum_q;
        cout_d      = out_load ? c[WIDTH] : cout_q;
        ovf_d       = out_load ? (c[WIDTH] ^ c[WIDTH-1]) : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_carry_sum_stage.sv
// tb_carry_sum_stage: scoreboard bench for carry_sum_stage with directed and random operands.
module tb_carry_sum_stage;
    localparam int W = 6;
`ifdef CARRY_SUM_MID_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] g = '0, p = '0, h = '0, sum;
    int           checks = 0, errors = 0;
    logic [7:0]   sb[$];

    // Directed vectors: x, y, cin and hand-computed {ovf, cout, sum}.
    logic [5:0] vx [8] = '{6'd45, 6'd31, 6'd63, 6'd32, 6'd0, 6'd10, 6'd63, 6'd20};
    logic [5:0] vy [8] = '{6'd19, 6'd1,  6'd0,  6'd32, 6'd0, 6'd5,  6'd63, 6'd12};
    logic       vc [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0, 1'b1,  1'b1,  1'b0};
    logic [7:0] ve [8] = '{8'b01_000000, 8'b10_100000, 8'b01_000000, 8'b11_000000,
                           8'b00_000000, 8'b00_010000, 8'b01_111111, 8'b10_100000};

    always #5 clk = ~clk;

    carry_sum_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .g(g), .p(p), .h(h), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [5:0] x, input logic [5:0] y, input logic c);
        logic [6:0] s;
        logic       v;
        s = {1'b0, x} + {1'b0, y} + {6'd0, c};
        v = (x[5] == y[5]) && (s[5] != x[5]);
        return {v, s[6], s[5:0]};
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [5:0] x, input logic [5:0] y, input logic c,
                        input logic [7:0] exp, output int waits);
        g = x & y;
        p = x | y;
        h = x ^ y;
        cin = c;
        in_valid = 1'b1;
        waits = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                break;
            end
            waits++;
            if (waits == 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waits);
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drained", {8'd0, sb.size() == 0}, 9'd1);
    endtask

    logic       pv = 1'b0, pr = 1'b1, prst = 1'b1;
    logic [8:0] pout = '0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (!prst && pv && !pr)
                chk("stall_hold", {out_valid, ovf, cout, sum}, pout);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h with empty scoreboard", {ovf, cout, sum});
                end else begin
                    chk("result", {1'b0, ovf, cout, sum}, {1'b0, sb.pop_front()});
                end
            end
        end
        pv   = out_valid;
        pr   = out_ready;
        prst = rst;
        pout = {out_valid, ovf, cout, sum};
    end

    initial begin
        int w, total;
        logic [5:0] x, y;
        logic c;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {8'd0, out_valid}, 9'd0);
        chk("rst_sum", {3'd0, sum}, 9'd0);
        chk("rst_cout", {8'd0, cout}, 9'd0);
        chk("rst_ovf", {8'd0, ovf}, 9'd0);
        chk("rst_in_ready", {8'd0, in_ready}, 9'd1);
        @(posedge clk);
        #1;

        send(vx[0], vy[0], vc[0], ve[0], w);
        @(negedge clk);
        chk("latency", {8'd0, out_valid}, {8'd0, LAT == 1});
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 8; i++) send(vx[i], vy[i], vc[i], ve[i], w);
        drain();

        out_ready = 1'b0;
        fork
            for (int i = 0; i < 4; i++) send(vx[i + 4], vy[i + 4], vc[i + 4], ve[i + 4], w);
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready", {8'd0, in_ready}, 9'd0);
                chk("bp_out_valid", {8'd0, out_valid}, 9'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        total = 0;
        for (int i = 0; i < 64; i++) begin
            x = 6'($urandom_range(0, 63));
            y = 6'($urandom_range(0, 63));
            c = 1'($urandom_range(0, 1));
            send(x, y, c, model(x, y, c), w);
            total += w;
        end
        chk("throughput_stalls", 9'(total), 9'd0);
        drain();

        out_ready = 1'b0;
        g = 6'b000001;
        p = 6'b111111;
        h = 6'b111110;
        cin = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {8'd0, out_valid}, 9'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_flush", {8'd0, out_valid}, 9'd0);
        repeat (5) @(negedge clk);
        chk("no_stale", {8'd0, out_valid}, 9'd0);
        chk("rst_sb_empty", {8'd0, sb.size() == 0}, 9'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
